serial_add_unit: RTL and testbench

//   Bit-serial ALU add stage for the 8086 datapath. Feeds one full_adder cell
//   one operand bit pair per clock, LSB first, and holds the inter-bit carry
//   in a flop. Collects the serial sum into a result register and generates
//   8086 arithmetic flags. Sits between the operand latches and the flags/

---
 rtl/serial_add_unit.sv | 188 ++++++++++++++++++
 tb/tb_serial_add_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// -----------------------------------------------------------------------------
// serial_add_unit
//   Bit-serial add stage for the 8086 ALU datapath. One full-adder cell is fed
//   one operand bit pair per clock, LSB first. The inter-bit carry lives in a
//   flop. The sum is assembled in place in the result register. The 8086
//   arithmetic flags are produced when the operation finishes. A start/ready/
//   done handshake connects the block to the control sequencer.
//
//   Optional feature macro: SERIAL_SUB_EN
//     When defined, the block adds a 'sub' port. With sub=1 it computes
//     A + ~B + ~borrow, and cf/af report borrow (the inverted carries).
//     When undefined, the block only adds, and the initial carry is cin.
//
// Parameters
//   WIDTH   operand/result width, 8 or 16
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts any operation in progress)
//   start   request, sampled only while ready=1
//   op_a    augend/minuend, captured on an accepted start
//   op_b    addend/subtrahend, captured on an accepted start
//   cin     carry-in (ADC) or borrow-in (SBB), captured on an accepted start
//   sub     subtract select (only with SERIAL_SUB_EN)
//   ready   high in IDLE
//   busy    high while bits are shifting
//   done    one-cycle pulse; result and flags are valid from here on
//   result  sum/difference, held until the next accepted start
//   cf,af,of,zf,sf,pf  8086 arithmetic flags, held until the next done
// -----------------------------------------------------------------------------
module serial_add_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             af,
  output logic             of,
  output logic             zf,
  output logic             sf,
  output logic             pf
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic             sub_q;
  logic             af_raw;      // carry out of bit 3, before borrow inversion
  logic             c_msb_in;    // carry into the MSB, kept for overflow
  logic             sub_in;
  logic             sum_bit;
  logic             cout_bit;
  logic             accept;
  logic             last_bit;

`ifdef SERIAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Single full-adder cell: {carry_out, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b,
                                          input logic c);
    full_add = {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  assign {cout_bit, sum_bit} = full_add(a_q[cnt], b_q[cnt], carry);
  assign accept   = (state == IDLE) && start;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // ---- control: state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---- control: next state and handshake outputs ----
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---- operand capture (subtrahend stored pre-inverted) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= sub_in ? ~op_b : op_b;
    end
  end

  // ---- serial datapath, result assembly and flag generation ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      sub_q    <= 1'b0;
      af_raw   <= 1'b0;
      c_msb_in <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      cf       <= 1'b0;
      af       <= 1'b0;
      of       <= 1'b0;
      zf       <= 1'b0;
      sf       <= 1'b0;
      pf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= '0;
            carry  <= cin ^ sub_in;  // subtract starts with ~borrow
            sub_q  <= sub_in;
            result <= '0;            // unwritten bits read as 0 mid-operation
          end
        end
        SHIFT: begin
          result[cnt] <= sum_bit;
          carry       <= cout_bit;
          if (cnt == CNT_W'(3)) af_raw <= cout_bit;
          if (last_bit) begin
            c_msb_in <= carry;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // result is complete here; done and flags become visible together
          done <= 1'b1;
          cf   <= carry ^ sub_q;
          af   <= af_raw ^ sub_q;
          of   <= c_msb_in ^ carry;
          zf   <= (result == '0);
          sf   <= result[WIDTH-1];
          pf   <= ~^result[7:0];
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_unit
//   Directed bench for serial_add_unit (WIDTH=16): reset state, additions with
//   hand-computed results and flags, done latency, start ignored while busy,
//   reset mid-operation, back-to-back throughput, and subtraction when the
//   SERIAL_SUB_EN macro is defined.
// -----------------------------------------------------------------------------
module tb_serial_add_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef SERIAL_SUB_EN
  logic         sub;
`endif
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cf, af, of, zf, sf, pf;
  logic [5:0]   flags;

  int total = 0;
  int bad   = 0;

  assign flags = {cf, af, of, zf, sf, pf};

  always #5 clk = ~clk;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
`ifdef SERIAL_SUB_EN
    .sub    (sub),
`endif
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cf     (cf),
    .af     (af),
    .of     (of),
    .zf     (zf),
    .sf     (sf),
    .pf     (pf)
  );

  // Starts an operation (caller is #1 after an edge with ready=1) and waits,
  // bounded, for done. lat = edges after the accepting edge, -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output int lat);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", result); end
    total++; if (flags !== 6'b000000) begin bad++; $display("FAIL reset_flags got=%b want=000000", flags); end
  endtask

  task automatic test_add();
    int lat;
    // 0x0001+0xFFFF: wraps to zero, carries everywhere
    run_op(16'h0001, 16'hFFFF, 1'b0, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL add1_latency got=%0d want=17", lat); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL add1_result got=%h want=0000", result); end
    total++; if (flags !== 6'b110101) begin bad++; $display("FAIL add1_flags(cf af of zf sf pf) got=%b want=110101", flags); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL add1_ready_at_done got=%b want=1", ready); end
    // 0x7FFF+0x0001: signed overflow
    run_op(16'h7FFF, 16'h0001, 1'b0, lat);
    total++; if (result !== 16'h8000) begin bad++; $display("FAIL add2_result got=%h want=8000", result); end
    total++; if (flags !== 6'b011011) begin bad++; $display("FAIL add2_flags(cf af of zf sf pf) got=%b want=011011", flags); end
    // 0x1234+0x0000 with carry-in
    run_op(16'h1234, 16'h0000, 1'b1, lat);
    total++; if (result !== 16'h1235) begin bad++; $display("FAIL add3_result got=%h want=1235", result); end
    total++; if (flags !== 6'b000001) begin bad++; $display("FAIL add3_flags(cf af of zf sf pf) got=%b want=000001", flags); end
    total++; if (lat !== 17) begin bad++; $display("FAIL add3_latency got=%0d want=17", lat); end
  endtask

`ifdef SERIAL_SUB_EN
  task automatic test_sub();
    int lat;
    sub = 1'b1;
    run_op(16'h0000, 16'h0001, 1'b0, lat);
    total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL sub1_result got=%h want=ffff", result); end
    total++; if (flags !== 6'b110011) begin bad++; $display("FAIL sub1_flags(cf af of zf sf pf) got=%b want=110011", flags); end
    run_op(16'h8000, 16'h0001, 1'b0, lat);
    total++; if (result !== 16'h7FFF) begin bad++; $display("FAIL sub2_result got=%h want=7fff", result); end
    total++; if (flags !== 6'b011001) begin bad++; $display("FAIL sub2_flags(cf af of zf sf pf) got=%b want=011001", flags); end
    sub = 1'b0;
  endtask
`endif

  task automatic test_ignore_start();
    int ndone;
    // 0x0FFF+0x1000 = 0x1FFF; a second start mid-operation must be dropped
    op_a  = 16'h0FFF;
    op_b  = 16'h1000;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // bits 0..3 written, upper bits cleared on accept
    total++; if (result !== 16'h000F) begin bad++; $display("FAIL partial_result got=%h want=000f", result); end
    total++; if (busy !== 1'b1 || ready !== 1'b0) begin bad++; $display("FAIL busy_mid_op got=busy%b/ready%b want=busy1/ready0", busy, ready); end
    op_a  = 16'hAAAA;
    op_b  = 16'h5555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        total++; if (result !== 16'h1FFF) begin bad++; $display("FAIL ignore_result got=%h want=1fff", result); end
        total++; if (flags !== 6'b000001) begin bad++; $display("FAIL ignore_flags(cf af of zf sf pf) got=%b want=000001", flags); end
      end
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int lat;
    op_a  = 16'h00FF;
    op_b  = 16'h0000;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    total++; if (result !== 16'h007F) begin bad++; $display("FAIL pre_reset_partial got=%h want=007f", result); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL abort_ready got=ready%b/busy%b want=ready1/busy0", ready, busy); end
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL abort_result got=%h want=0000", result); end
    total++; if (flags !== 6'b000000) begin bad++; $display("FAIL abort_flags got=%b want=000000", flags); end
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", ndone); end
    run_op(16'h0003, 16'h0004, 1'b0, lat);
    total++; if (lat !== 17) begin bad++; $display("FAIL after_abort_latency got=%0d want=17", lat); end
    total++; if (result !== 16'h0007) begin bad++; $display("FAIL after_abort_result got=%h want=0007", result); end
    total++; if (flags !== 6'b000000) begin bad++; $display("FAIL after_abort_flags(cf af of zf sf pf) got=%b want=000000", flags); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [W-1:0] r1, r2;
    d1 = -1;
    d2 = -1;
    r1 = 'x;
    r2 = 'x;
    op_a  = 16'h0100;
    op_b  = 16'h0200;
    cin   = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 80 && d2 < 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (d1 < 0) begin
          d1   = i;
          r1   = result;
          op_a = 16'h0005;
          op_b = 16'h0006;
        end else begin
          d2 = i;
          r2 = result;
        end
      end
    end
    start = 1'b0;
    total++; if (d1 !== 18) begin bad++; $display("FAIL b2b_first_done_edge got=%0d want=18", d1); end
    total++; if (r1 !== 16'h0300) begin bad++; $display("FAIL b2b_first_result got=%h want=0300", r1); end
    total++; if (d2 - d1 !== 18) begin bad++; $display("FAIL b2b_interval got=%0d want=18", d2 - d1); end
    total++; if (r2 !== 16'h000B) begin bad++; $display("FAIL b2b_second_result got=%h want=000b", r2); end
  endtask

  initial begin
    test_reset();
    test_add();
`ifdef SERIAL_SUB_EN
    test_sub();
`endif
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
